// File: rtl/ram_pkg.sv
// Shared types for the dual-port pipelined RAM: write modes, latency cap and a word/byte-lane view.
package ram_pkg;

    typedef enum logic [1:0] {
        RD_FIRST  = 2'd0,
        WR_FIRST  = 2'd1,
        NO_CHANGE = 2'd2
    } wmode_e;

    localparam int MAX_READ_LATENCY = 4;

    localparam int RVIEW_DATA_WIDTH = 64;
    localparam int RVIEW_BYTE_WIDTH = 8;
    localparam int RVIEW_BYTES      = RVIEW_DATA_WIDTH / RVIEW_BYTE_WIDTH;

    // Default-width view; modules with other widths declare the same shape from their own parameters.
    typedef union packed {
        logic [RVIEW_DATA_WIDTH-1:0]                     word;
        logic [RVIEW_BYTES-1:0][RVIEW_BYTE_WIDTH-1:0]    lanes;
    } rview_t;

    function automatic int clamp_latency(input int lat);
        if (lat < 1)
            return 1;
        if (lat > MAX_READ_LATENCY)
            return MAX_READ_LATENCY;
        return lat;
    endfunction

endpackage

// File: rtl/ram_dualport_pipe_resp_pipe.sv
// Per-port response pipeline: acceptance, whole-pipeline stall, and write-mode selection of response data.
module ram_resp_pipe
    import ram_pkg::*;
#(
    parameter int     DATA_WIDTH = 64,
    parameter int     LATENCY    = 2,
    parameter wmode_e MODE       = RD_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  accept,
    input  logic                  is_write,
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic                  resp_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int LAT = clamp_latency(LATENCY);

    logic                  stall;
    logic                  cap_keep;
    logic [DATA_WIDTH-1:0] cap_dat;
    logic                  feed_vld;
    logic                  feed_keep;
    logic [DATA_WIDTH-1:0] feed_dat;

    assign stall     = resp_valid && !resp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;

    // A keep flag marks a NO_CHANGE write: the output register is left untouched when it arrives.
    always_comb begin
        cap_keep = 1'b0;
        cap_dat  = old_word;
        if (is_write) begin
            case (MODE)
                WR_FIRST:  cap_dat  = new_word;
                NO_CHANGE: cap_keep = 1'b1;
                default:   cap_dat  = old_word;
            endcase
        end
    end

    if (LAT == 1) begin : g_direct
        assign feed_vld  = accept;
        assign feed_keep = cap_keep;
        assign feed_dat  = cap_dat;
    end else begin : g_front
        logic [LAT-2:0]        vld;
        logic [LAT-2:0]        keep;
        logic [DATA_WIDTH-1:0] dat [LAT-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld  <= '0;
                keep <= '0;
                for (int i = 0; i < LAT - 1; i++)
                    dat[i] <= '0;
            end else if (!stall) begin
                vld[0]  <= accept;
                keep[0] <= cap_keep;
                dat[0]  <= cap_dat;
                for (int i = 1; i < LAT - 1; i++) begin
                    vld[i]  <= vld[i-1];
                    keep[i] <= keep[i-1];
                    dat[i]  <= dat[i-1];
                end
            end
        end

        assign feed_vld  = vld[LAT-2];
        assign feed_keep = keep[LAT-2];
        assign feed_dat  = dat[LAT-2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            rdata      <= '0;
        end else if (!stall) begin
            resp_valid <= feed_vld;
            if (feed_vld && !feed_keep)
                rdata <= feed_dat;
        end
    end

endmodule

// File: rtl/ram_dualport_pipe.sv
// True dual-port byte-writable RAM with per-port pipelined responses and cross-port collision merge.
// Optional collision flag output enabled by defining RAM_COLLISION_FLAG_EN.
module ram_dualport_pipe
    import ram_pkg::*;
#(
    parameter int     ADDR_WIDTH   = 10,
    parameter int     DATA_WIDTH   = 64,
    parameter int     BYTE_WIDTH   = 8,
    parameter int     READ_LATENCY = 2,
    parameter wmode_e WRITE_MODE_A = RD_FIRST,
    parameter wmode_e WRITE_MODE_B = RD_FIRST
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             a_req_valid,
    output logic                             a_req_ready,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_strobe,
    input  logic [DATA_WIDTH-1:0]            a_wdata,
    output logic                             a_resp_valid,
    input  logic                             a_resp_ready,
    output logic [DATA_WIDTH-1:0]            a_rdata,
    input  logic                             b_req_valid,
    output logic                             b_req_ready,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_strobe,
    input  logic [DATA_WIDTH-1:0]            b_wdata,
    output logic                             b_resp_valid,
    input  logic                             b_resp_ready,
    output logic [DATA_WIDTH-1:0]            b_rdata
`ifdef RAM_COLLISION_FLAG_EN
    ,
    output logic                             collision
`endif
);

    localparam int BYTES     = DATA_WIDTH / BYTE_WIDTH;
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    typedef union packed {
        logic [DATA_WIDTH-1:0]                 word;
        logic [BYTES-1:0][BYTE_WIDTH-1:0]      lanes;
    } lane_view_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [BYTES-1:0]      strobe
    );
        lane_view_t b;
        lane_view_t w;
        b.word = base;
        w.word = wdata;
        for (int i = 0; i < BYTES; i++)
            if (strobe[i])
                b.lanes[i] = w.lanes[i];
        return b.word;
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  a_accept;
    logic                  b_accept;
    logic                  a_wr;
    logic                  b_wr;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] a_old;
    logic [DATA_WIDTH-1:0] b_old;
    logic [DATA_WIDTH-1:0] a_merge;
    logic [DATA_WIDTH-1:0] b_merge;
    logic [DATA_WIDTH-1:0] ab_merge;
    logic [DATA_WIDTH-1:0] a_new;
    logic [DATA_WIDTH-1:0] b_new;

    assign a_old     = mem[a_addr];
    assign b_old     = mem[b_addr];
    assign same_addr = (a_addr == b_addr);
    assign a_wr      = a_accept && (|a_strobe);
    assign b_wr      = b_accept && (|b_strobe);

    // On a same-address double write the stored word is B's bytes overlaid by A's bytes.
    assign a_merge  = merge_bytes(a_old, a_wdata, a_strobe);
    assign b_merge  = merge_bytes(b_old, b_wdata, b_strobe);
    assign ab_merge = merge_bytes(b_merge, a_wdata, a_strobe);
    assign a_new    = (same_addr && b_wr) ? ab_merge : a_merge;
    assign b_new    = (same_addr && a_wr) ? ab_merge : b_merge;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (a_wr && a_strobe[i])
                mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (b_wr && b_strobe[i] && !(same_addr && a_wr && a_strobe[i]))
                mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    ram_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY),
        .MODE       (WRITE_MODE_A)
    ) u_pipe_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .accept     (a_accept),
        .is_write   (|a_strobe),
        .old_word   (a_old),
        .new_word   (a_new),
        .resp_ready (a_resp_ready),
        .resp_valid (a_resp_valid),
        .rdata      (a_rdata)
    );

    ram_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY),
        .MODE       (WRITE_MODE_B)
    ) u_pipe_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .accept     (b_accept),
        .is_write   (|b_strobe),
        .old_word   (b_old),
        .new_word   (b_new),
        .resp_ready (b_resp_ready),
        .resp_valid (b_resp_valid),
        .rdata      (b_rdata)
    );

`ifdef RAM_COLLISION_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            collision <= 1'b0;
        else
            collision <= a_accept && b_accept && same_addr && ((|a_strobe) || (|b_strobe));
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && a_wr && b_wr && same_addr && (|(a_strobe & b_strobe)))
            $warning("ram_dualport_pipe: overlapping write-write collision at addr %0h", a_addr);
    end
`endif
`endif

endmodule

// File: tb/tb_ram_dualport_pipe.sv
// Directed self-checking bench for ram_dualport_pipe: main instance (latency 2) and a latency-1 NO_CHANGE instance.
module tb_ram_dualport_pipe;
    import ram_pkg::*;

    logic        clk;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [9:0]  a_addr;
    logic [7:0]  a_strobe;
    logic [63:0] a_wdata, a_rdata;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [9:0]  b_addr;
    logic [7:0]  b_strobe;
    logic [63:0] b_wdata, b_rdata;

    logic        x_req_valid, x_req_ready, x_resp_valid, x_resp_ready;
    logic [9:0]  x_addr;
    logic [7:0]  x_strobe;
    logic [63:0] x_wdata, x_rdata;
    logic        y_req_ready, y_resp_valid;
    logic [63:0] y_rdata;
`ifdef RAM_COLLISION_FLAG_EN
    logic        collision;
    logic        x_collision;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ram_dualport_pipe #(
        .READ_LATENCY (2),
        .WRITE_MODE_A (RD_FIRST),
        .WRITE_MODE_B (WR_FIRST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_addr       (a_addr),
        .a_strobe     (a_strobe),
        .a_wdata      (a_wdata),
        .a_resp_valid (a_resp_valid),
        .a_resp_ready (a_resp_ready),
        .a_rdata      (a_rdata),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_addr       (b_addr),
        .b_strobe     (b_strobe),
        .b_wdata      (b_wdata),
        .b_resp_valid (b_resp_valid),
        .b_resp_ready (b_resp_ready),
        .b_rdata      (b_rdata)
`ifdef RAM_COLLISION_FLAG_EN
        ,
        .collision    (collision)
`endif
    );

    ram_dualport_pipe #(
        .READ_LATENCY (1),
        .WRITE_MODE_A (NO_CHANGE),
        .WRITE_MODE_B (RD_FIRST)
    ) dut_nc (
        .clk          (clk),
        .reset        (reset),
        .a_req_valid  (x_req_valid),
        .a_req_ready  (x_req_ready),
        .a_addr       (x_addr),
        .a_strobe     (x_strobe),
        .a_wdata      (x_wdata),
        .a_resp_valid (x_resp_valid),
        .a_resp_ready (x_resp_ready),
        .a_rdata      (x_rdata),
        .b_req_valid  (1'b0),
        .b_req_ready  (y_req_ready),
        .b_addr       (10'd0),
        .b_strobe     (8'd0),
        .b_wdata      (64'd0),
        .b_resp_valid (y_resp_valid),
        .b_resp_ready (1'b1),
        .b_rdata      (y_rdata)
`ifdef RAM_COLLISION_FLAG_EN
        ,
        .collision    (x_collision)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [9:0] ad, input logic [7:0] st, input logic [63:0] wd);
        a_req_valid = v; a_addr = ad; a_strobe = st; a_wdata = wd;
    endtask

    task automatic drive_b(input logic v, input logic [9:0] ad, input logic [7:0] st, input logic [63:0] wd);
        b_req_valid = v; b_addr = ad; b_strobe = st; b_wdata = wd;
    endtask

    task automatic drive_x(input logic v, input logic [9:0] ad, input logic [7:0] st, input logic [63:0] wd);
        x_req_valid = v; x_addr = ad; x_strobe = st; x_wdata = wd;
    endtask

    initial begin
        reset = 1'b0;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        drive_x(0, 0, 0, 0);
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        x_resp_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_a_valid", a_resp_valid, 0);
        check_val("rst_b_valid", b_resp_valid, 0);
        check_val("rst_a_rdata", a_rdata, 0);
        check_val("rst_b_rdata", b_rdata, 0);
        reset = 1'b0;
        #1;
        check_val("rst_a_ready", a_req_ready, 1);
        check_val("rst_b_ready", b_req_ready, 1);
        step();

        // known contents for addresses used below
        drive_a(1, 9, 8'hFF, 64'h0);  step();
        drive_a(1, 3, 8'hFF, 64'h10); step();
        drive_a(1, 5, 8'hFF, 64'h0);  step();
        drive_a(0, 0, 0, 0);          step(); step(); step();

        // write then read same address on port A
        drive_a(1, 5, 8'hFF, 64'h1122334455667788); step();
        drive_a(1, 5, 8'h00, 64'h0);                step();
        check_val("raw_wr_valid", a_resp_valid, 1);
        check_val("raw_wr_old",   a_rdata, 64'h0);
        drive_a(0, 0, 0, 0); step();
        check_val("raw_rd_valid", a_resp_valid, 1);
        check_val("raw_rd_data",  a_rdata, 64'h1122334455667788);
        step();
        check_val("raw_idle", a_resp_valid, 0);

        // partial strobe write on B (WR_FIRST returns merged word), then read back on A
        drive_b(1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA); step();
        drive_b(0, 0, 0, 0); step();
        check_val("part_b_valid", b_resp_valid, 1);
        check_val("part_b_merged", b_rdata, 64'h11223344AAAAAAAA);
        drive_a(1, 5, 8'h00, 64'h0); step();
        drive_a(0, 0, 0, 0); step();
        check_val("part_rd", a_rdata, 64'h11223344AAAAAAAA);
        step();

        // write-write collision at addr 9
        drive_a(1, 9, 8'h01, 64'h1);
        drive_b(1, 9, 8'h03, 64'hFFFF);
        step();
`ifdef RAM_COLLISION_FLAG_EN
        check_val("ww_flag", collision, 1);
`endif
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        step();
`ifdef RAM_COLLISION_FLAG_EN
        check_val("ww_flag_clear", collision, 0);
`endif
        check_val("ww_a_old",    a_rdata, 64'h0);
        check_val("ww_b_merged", b_rdata, 64'hFF01);
        drive_a(1, 9, 8'h00, 64'h0); step();
        drive_a(0, 0, 0, 0); step();
        check_val("ww_readback", a_rdata, 64'hFF01);
        step();

        // write modes at addr 3 (holds 0x10)
        drive_a(1, 3, 8'hFF, 64'h20); step();
        drive_a(0, 0, 0, 0); step();
        check_val("mode_rd_first", a_rdata, 64'h10);
        drive_b(1, 3, 8'hFF, 64'h30); step();
        drive_b(0, 0, 0, 0); step();
        check_val("mode_wr_first", b_rdata, 64'h30);
        step();

        // A reads while B writes the same address
        drive_a(1, 5, 8'h00, 64'h0);
        drive_b(1, 5, 8'hFF, 64'h0);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        step();
        check_val("rw_reader_old", a_rdata, 64'h11223344AAAAAAAA);
        check_val("rw_writer_new", b_rdata, 64'h0);
        step();

        // backpressure on A with reads of 9, 3, 5
        a_resp_ready = 1'b0;
        drive_a(1, 9, 8'h00, 64'h0); step();
        drive_a(1, 3, 8'h00, 64'h0); step();
        drive_a(1, 5, 8'h00, 64'h0);
        check_val("bp_ready_low", a_req_ready, 0);
        check_val("bp_valid",     a_resp_valid, 1);
        check_val("bp_data0",     a_rdata, 64'hFF01);
        step();
        check_val("bp_ready_held", a_req_ready, 0);
        check_val("bp_data_stable", a_rdata, 64'hFF01);
        a_resp_ready = 1'b1;
        step();
        drive_a(0, 0, 0, 0);
        check_val("bp_data1", a_rdata, 64'h30);
        step();
        check_val("bp_valid2", a_resp_valid, 1);
        check_val("bp_data2",  a_rdata, 64'h0);
        step();
        check_val("bp_drained", a_resp_valid, 0);

        // latency-1 instance, NO_CHANGE on its port A
        drive_x(1, 4, 8'hFF, 64'h44); step();
        check_val("nc_l1_valid", x_resp_valid, 1);
        check_val("nc_first_hold", x_rdata, 64'h0);
        drive_x(1, 4, 8'h00, 64'h0); step();
        check_val("nc_l1_read", x_rdata, 64'h44);
        drive_x(1, 4, 8'hFF, 64'h55); step();
        check_val("nc_hold_valid", x_resp_valid, 1);
        check_val("nc_hold_prior", x_rdata, 64'h44);
        drive_x(1, 4, 8'h00, 64'h0); step();
        check_val("nc_read_new", x_rdata, 64'h55);
        drive_x(0, 0, 0, 0); step();
        check_val("nc_idle", x_resp_valid, 0);

        // reset with two reads in flight; B write to addr 7 accepted before reset
        drive_a(1, 9, 8'h00, 64'h0); step();
        drive_a(1, 3, 8'h00, 64'h0);
        drive_b(1, 7, 8'hFF, 64'h77);
        step();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        check_val("pre_rst_valid", a_resp_valid, 1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_a_valid", a_resp_valid, 0);
        check_val("mid_rst_a_rdata", a_rdata, 64'h0);
        step();
        reset = 1'b0;
        #1;
        check_val("post_rst_ready", a_req_ready, 1);
        step();
        check_val("post_rst_b_valid", b_resp_valid, 0);
        drive_a(1, 7, 8'h00, 64'h0); step();
        drive_a(1, 3, 8'h00, 64'h0); step();
        drive_a(0, 0, 0, 0);
        check_val("persist_addr7", a_rdata, 64'h77);
        step();
        check_val("persist_addr3", a_rdata, 64'h30);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
